// File: rtl/ltc_2656_listener.sv
// LTC-2656 serial-interface responder: decodes 24/32-bit frames into a behavioral image of the DAC registers.
// Optional LTC2656_LISTENER_SYNC_EN adds a 2-flop synchronizer on every pin input.
module ltc_2656_listener #(
   parameter logic [15:0] RESET_CODE = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sck,
   input  logic        sdi,
   input  logic        csld,
   input  logic        ldac_n,
   input  logic        clr_n,
   output logic        frame_valid,
   output logic        frame_error,
   output logic [3:0]  frame_cmd,
   output logic [3:0]  frame_addr,
   output logic [15:0] frame_data,
   input  logic [2:0]  rd_ch,
   output logic [15:0] rd_input,
   output logic [15:0] rd_dac,
   output logic [7:0]  power_down,
   output logic        ref_external
);

   // pin order {clr_n, ldac_n, csld, sdi, sck}; idle levels keep reset from faking an edge
   localparam logic [4:0] PIN_IDLE = 5'b11100;

   logic [4:0] pins_raw, pins_src, pins_r;
   assign pins_raw = {clr_n, ldac_n, csld, sdi, sck};

`ifdef LTC2656_LISTENER_SYNC_EN
   logic [4:0] sync1, sync2;
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= PIN_IDLE;
         sync2 <= PIN_IDLE;
      end else begin
         sync1 <= pins_raw;
         sync2 <= sync1;
      end
   end
   assign pins_src = sync2;
`else
   assign pins_src = pins_raw;
`endif

   logic sck_r, sdi_r, csld_r, ldac_r, clr_r;
   logic sck_d, csld_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         pins_r <= PIN_IDLE;
         sck_d  <= 1'b0;
         csld_d <= 1'b1;
      end else begin
         pins_r <= pins_src;
         sck_d  <= sck_r;
         csld_d <= csld_r;
      end
   end

   assign {clr_r, ldac_r, csld_r, sdi_r, sck_r} = pins_r;

   logic sck_rise, csld_fall, frame_end;
   assign sck_rise  = sck_r & ~sck_d & ~csld_r;
   assign csld_fall = ~csld_r & csld_d;
   assign frame_end = csld_r & ~csld_d;

   // Only the last 24 bits are ever decoded; the leading byte of a 32-bit frame just shifts out.
   logic [23:0] shreg;
   logic [5:0]  bit_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg     <= '0;
         bit_count <= '0;
      end else begin
         if (sck_rise)
            shreg <= {shreg[22:0], sdi_r};
         if (csld_fall)
            bit_count <= '0;
         else if (sck_rise && bit_count != 6'd33)
            bit_count <= bit_count + 6'd1;
      end
   end

   logic [3:0]  cmd, addr;
   logic [15:0] data;
   logic        len_ok, addr_ok, cmd_ok, exec, addr_all;
   assign cmd      = shreg[23:20];
   assign addr     = shreg[19:16];
   assign data     = shreg[15:0];
   assign addr_all = (addr == 4'hF);
   assign len_ok   = (bit_count == 6'd24) || (bit_count == 6'd32);
   assign addr_ok  = ~addr[3] | addr_all;
   assign cmd_ok   = ~cmd[3] | (cmd == 4'hF);
   assign exec     = frame_end & len_ok & addr_ok & cmd_ok;

   logic c0, c1, c2, c3, c4, c5, c6, c7;
   assign c0 = exec & (cmd == 4'h0);
   assign c1 = exec & (cmd == 4'h1);
   assign c2 = exec & (cmd == 4'h2);
   assign c3 = exec & (cmd == 4'h3);
   assign c4 = exec & (cmd == 4'h4);
   assign c5 = exec & (cmd == 4'h5);
   assign c6 = exec & (cmd == 4'h6);
   assign c7 = exec & (cmd == 4'h7);

   logic [7:0][15:0] in_reg, dac_reg, in_next, dac_next;
   logic [7:0]       sel, pd_set, pd_clr;

   // cmd 0x2 updates every DAC from the post-write input image, as LDAC does
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         sel[i]      = addr_all | (~addr[3] & (addr[2:0] == 3'(i)));
         in_next[i]  = (sel[i] & (c0 | c2 | c3)) ? data : in_reg[i];
         dac_next[i] = (~ldac_r | c2 | (sel[i] & (c1 | c3))) ? in_next[i] : dac_reg[i];
         pd_set[i]   = c5 | (sel[i] & c4);
         pd_clr[i]   = c2 | (sel[i] & (c1 | c3));
      end
   end

   always_ff @(posedge clk) begin
      if (reset || !clr_r) begin
         for (int i = 0; i < 8; i++) begin
            in_reg[i]  <= RESET_CODE;
            dac_reg[i] <= RESET_CODE;
         end
      end else begin
         in_reg  <= in_next;
         dac_reg <= dac_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         power_down   <= 8'h00;
         ref_external <= 1'b0;
         frame_valid  <= 1'b0;
         frame_error  <= 1'b0;
         frame_cmd    <= 4'h0;
         frame_addr   <= 4'h0;
         frame_data   <= 16'h0000;
      end else begin
         power_down  <= (power_down & ~pd_clr) | pd_set;
         if (c6)
            ref_external <= 1'b0;
         else if (c7)
            ref_external <= 1'b1;
         frame_valid <= exec;
         frame_error <= frame_end & ~exec;
         if (exec) begin
            frame_cmd  <= cmd;
            frame_addr <= addr;
            frame_data <= data;
         end
      end
   end

   assign rd_input = in_reg[rd_ch];
   assign rd_dac   = dac_reg[rd_ch];

endmodule

// File: tb/tb_ltc_2656_listener.sv
// Scoreboard bench for ltc_2656_listener: frames are queued as expected pulses and checked when the DUT reports them.
module tb_ltc_2656_listener;
   localparam logic [15:0] RC = 16'h8000;

   logic        clk = 1'b0;
   logic        reset, sck, sdi, csld, ldac_n, clr_n;
   logic        frame_valid, frame_error;
   logic [3:0]  frame_cmd, frame_addr;
   logic [15:0] frame_data, rd_input, rd_dac;
   logic [2:0]  rd_ch;
   logic [7:0]  power_down;
   logic        ref_external;

   ltc_2656_listener #(.RESET_CODE(RC)) dut (
      .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .csld(csld), .ldac_n(ldac_n), .clr_n(clr_n),
      .frame_valid(frame_valid), .frame_error(frame_error), .frame_cmd(frame_cmd),
      .frame_addr(frame_addr), .frame_data(frame_data), .rd_ch(rd_ch), .rd_input(rd_input),
      .rd_dac(rd_dac), .power_down(power_down), .ref_external(ref_external));

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [3:0]  cmd;
      logic [3:0]  addr;
      logic [15:0] data;
   } exp_t;

   exp_t        sb[$];
   exp_t        sb_e;
   int          total = 0, bad = 0, vld_cnt = 0;
   logic [15:0] exp_in[8], exp_dac[8];
   logic [3:0]  last_cmd = 4'h0, last_addr = 4'h0;
   logic [15:0] last_data = 16'h0;

   // scoreboard monitor: every reported frame must match the head of the queue
   always @(negedge clk) begin
      if (!reset && (frame_valid || frame_error)) begin
         total++;
         if (frame_valid && frame_error) begin
            bad++;
            $display("FAIL both_pulses valid=%b error=%b want exclusive", frame_valid, frame_error);
         end
         if (frame_valid) vld_cnt++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse valid=%b error=%b want none", frame_valid, frame_error);
         end else begin
            sb_e = sb.pop_front();
            if (sb_e.err) begin
               sb_e.cmd = last_cmd; sb_e.addr = last_addr; sb_e.data = last_data;
            end
            if ({frame_error, frame_cmd, frame_addr, frame_data} !== {sb_e.err, sb_e.cmd, sb_e.addr, sb_e.data}) begin
               bad++;
               $display("FAIL frame_report got err=%b %h/%h/%h want err=%b %h/%h/%h", frame_error,
                        frame_cmd, frame_addr, frame_data, sb_e.err, sb_e.cmd, sb_e.addr, sb_e.data);
            end
            if (!sb_e.err) begin
               last_cmd = sb_e.cmd; last_addr = sb_e.addr; last_data = sb_e.data;
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic push(input logic err, input logic [23:0] w);
      exp_t e;
      e.err = err; e.cmd = w[23:20]; e.addr = w[19:16]; e.data = w[15:0];
      sb.push_back(e);
   endtask

   task automatic shift_frame(input logic [31:0] w, input int n);
      csld = 1'b0;
      @(posedge clk); #1;
      for (int i = n - 1; i >= 0; i--) begin
         sdi = w[i]; sck = 1'b0;
         @(posedge clk); #1;
         sck = 1'b1;
         @(posedge clk); #1;
      end
      sck = 1'b0;
   endtask

   task automatic end_frame();
      csld = 1'b1;
      idle(4);
   endtask

   task automatic send(input logic [23:0] w);
      push(1'b0, w);
      shift_frame({8'h00, w}, 24);
      end_frame();
   endtask

   task automatic model_reset();
      for (int c = 0; c < 8; c++) begin exp_in[c] = RC; exp_dac[c] = RC; end
      last_cmd = 4'h0; last_addr = 4'h0; last_data = 16'h0;
   endtask

   task automatic test_reset();
      reset = 1'b1; sck = 1'b0; sdi = 1'b0; csld = 1'b1; ldac_n = 1'b1; clr_n = 1'b1; rd_ch = 3'd0;
      model_reset();
      idle(3);
      reset = 1'b0;
      idle(2);
      total++;
      if ({frame_valid, frame_error, frame_cmd, frame_addr, frame_data, power_down, ref_external} !== 35'h0) begin
         bad++;
         $display("FAIL reset_outputs got v=%b e=%b %h/%h/%h pd=%h ref=%b want all zero", frame_valid,
                  frame_error, frame_cmd, frame_addr, frame_data, power_down, ref_external);
      end
      for (int c = 0; c < 8; c++) begin
         rd_ch = 3'(c); #1; total++;
         if (rd_input !== RC || rd_dac !== RC) begin
            bad++;
            $display("FAIL reset_regs ch%0d in=%h dac=%h want %h", c, rd_input, rd_dac, RC);
         end
      end
   endtask

   task automatic test_write_update();
      push(1'b0, 24'h33ABCD);
      shift_frame(32'h0033ABCD, 24);
      csld = 1'b1;
      @(posedge clk); #1;
      total++;
      if (frame_valid !== 1'b0) begin
         bad++; $display("FAIL latency_early valid=%b want 0", frame_valid);
      end
      @(posedge clk); #1;
      total++;
      if (frame_valid !== 1'b1) begin
         bad++; $display("FAIL latency_pulse valid=%b want 1", frame_valid);
      end
      idle(3);
      exp_in[3] = 16'hABCD; exp_dac[3] = 16'hABCD;
      for (int c = 0; c < 8; c++) begin
         rd_ch = 3'(c); #1; total++;
         if (rd_input !== exp_in[c] || rd_dac !== exp_dac[c]) begin
            bad++;
            $display("FAIL write_update ch%0d in=%h dac=%h want %h %h", c, rd_input, rd_dac, exp_in[c], exp_dac[c]);
         end
      end
   endtask

   task automatic test_broadcast_ldac();
      push(1'b0, 24'h0F1234);
      shift_frame(32'hFF0F1234, 32);
      end_frame();
      for (int c = 0; c < 8; c++) exp_in[c] = 16'h1234;
      for (int c = 0; c < 8; c++) begin
         rd_ch = 3'(c); #1; total++;
         if (rd_input !== exp_in[c] || rd_dac !== exp_dac[c]) begin
            bad++;
            $display("FAIL broadcast ch%0d in=%h dac=%h want %h %h", c, rd_input, rd_dac, exp_in[c], exp_dac[c]);
         end
      end
      @(posedge clk); #1;
      ldac_n = 1'b0;
      @(posedge clk); #1;
      ldac_n = 1'b1;
      idle(4);
      for (int c = 0; c < 8; c++) exp_dac[c] = 16'h1234;
      for (int c = 0; c < 8; c++) begin
         rd_ch = 3'(c); #1; total++;
         if (rd_dac !== exp_dac[c]) begin
            bad++; $display("FAIL ldac_pulse ch%0d dac=%h want %h", c, rd_dac, exp_dac[c]);
         end
      end
   endtask

   task automatic test_bad_frames();
      int v0;
      v0 = vld_cnt;
      push(1'b1, 24'h0);
      shift_frame(32'h0031_7777 >> 1, 23);
      end_frame();
      push(1'b1, 24'h0);
      shift_frame(32'h00381111, 24);
      end_frame();
      push(1'b1, 24'h0);
      shift_frame(32'h00901111, 24);
      end_frame();
      total++;
      if (vld_cnt !== v0) begin
         bad++; $display("FAIL bad_no_valid count=%0d want %0d", vld_cnt, v0);
      end
      for (int c = 0; c < 8; c++) begin
         rd_ch = 3'(c); #1; total++;
         if (rd_input !== exp_in[c] || rd_dac !== exp_dac[c]) begin
            bad++;
            $display("FAIL bad_no_effect ch%0d in=%h dac=%h want %h %h", c, rd_input, rd_dac, exp_in[c], exp_dac[c]);
         end
      end
      send(24'h317777);
      exp_in[1] = 16'h7777; exp_dac[1] = 16'h7777;
      rd_ch = 3'd1; #1; total++;
      if (rd_input !== 16'h7777 || rd_dac !== 16'h7777) begin
         bad++; $display("FAIL after_bad ch1 in=%h dac=%h want 7777", rd_input, rd_dac);
      end
   endtask

   task automatic test_power_ref();
      send(24'h054321);
      exp_in[5] = 16'h4321;
      rd_ch = 3'd5; #1; total++;
      if (rd_input !== 16'h4321 || rd_dac !== 16'h1234) begin
         bad++; $display("FAIL input_only ch5 in=%h dac=%h want 4321 1234", rd_input, rd_dac);
      end
      send(24'h450000);
      total++;
      if (power_down !== 8'h20) begin
         bad++; $display("FAIL pd_ch5 got %h want 20", power_down);
      end
      send(24'h150000);
      exp_dac[5] = 16'h4321;
      total++;
      if (power_down !== 8'h00 || rd_dac !== 16'h4321) begin
         bad++; $display("FAIL update_ch5 pd=%h dac=%h want 00 4321", power_down, rd_dac);
      end
      send(24'h700000);
      total++;
      if (ref_external !== 1'b1) begin
         bad++; $display("FAIL ref_ext got %b want 1", ref_external);
      end
      send(24'h6F0000);
      total++;
      if (ref_external !== 1'b0) begin
         bad++; $display("FAIL ref_int got %b want 0", ref_external);
      end
      send(24'h5F0000);
      total++;
      if (power_down !== 8'hFF) begin
         bad++; $display("FAIL pd_all got %h want ff", power_down);
      end
      send(24'hF3FFFF);
      send(24'h20AAAA);
      exp_in[0] = 16'hAAAA;
      for (int c = 0; c < 8; c++) exp_dac[c] = exp_in[c];
      total++;
      if (power_down !== 8'h00) begin
         bad++; $display("FAIL cmd2_powerup got %h want 00", power_down);
      end
      for (int c = 0; c < 8; c++) begin
         rd_ch = 3'(c); #1; total++;
         if (rd_input !== exp_in[c] || rd_dac !== exp_dac[c]) begin
            bad++;
            $display("FAIL cmd2_update ch%0d in=%h dac=%h want %h %h", c, rd_input, rd_dac, exp_in[c], exp_dac[c]);
         end
      end
   endtask

   task automatic test_clear();
      clr_n = 1'b0;
      idle(3);
      send(24'h305555);
      send(24'h420000);
      total++;
      if (frame_data !== 16'h5555 - 16'h5555 || power_down !== 8'h04) begin
         bad++; $display("FAIL clr_side data=%h pd=%h want 0000 04", frame_data, power_down);
      end
      clr_n = 1'b1;
      idle(3);
      for (int c = 0; c < 8; c++) begin exp_in[c] = RC; exp_dac[c] = RC; end
      for (int c = 0; c < 8; c++) begin
         rd_ch = 3'(c); #1; total++;
         if (rd_input !== RC || rd_dac !== RC) begin
            bad++; $display("FAIL clr_hold ch%0d in=%h dac=%h want %h", c, rd_input, rd_dac, RC);
         end
      end
   endtask

   task automatic test_back_to_back();
      push(1'b0, 24'h021111);
      push(1'b0, 24'h120000);
      shift_frame(32'h00021111, 24);
      csld = 1'b1;
      @(posedge clk); #1;
      shift_frame(32'h00120000, 24);
      end_frame();
      rd_ch = 3'd2; #1; total++;
      if (rd_input !== 16'h1111 || rd_dac !== 16'h1111 || power_down !== 8'h00) begin
         bad++; $display("FAIL back_to_back in=%h dac=%h pd=%h want 1111 1111 00", rd_input, rd_dac, power_down);
      end
   endtask

   task automatic test_reset_midframe();
      int v0;
      shift_frame(32'h00A5A5A5, 12);
      reset = 1'b1; csld = 1'b1;
      idle(3);
      reset = 1'b0;
      model_reset();
      idle(2);
      v0 = vld_cnt;
      send(24'h37BEEF);
      total++;
      if (vld_cnt !== v0 + 1 || frame_data !== 16'hBEEF) begin
         bad++; $display("FAIL reset_mid valids=%0d data=%h want %0d BEEF", vld_cnt - v0, frame_data, 1);
      end
      rd_ch = 3'd7; #1; total++;
      if (rd_input !== 16'hBEEF || rd_dac !== 16'hBEEF) begin
         bad++; $display("FAIL reset_mid_ch7 in=%h dac=%h want BEEF", rd_input, rd_dac);
      end
      rd_ch = 3'd1; #1; total++;
      if (rd_dac !== RC) begin
         bad++; $display("FAIL reset_mid_ch1 dac=%h want %h", rd_dac, RC);
      end
   endtask

   initial begin
      test_reset();
      test_write_update();
      test_broadcast_ldac();
      test_bad_frames();
      test_power_ref();
      test_clear();
      test_back_to_back();
      test_reset_midframe();
      idle(4);
      total++;
      if (sb.size() != 0) begin
         bad++; $display("FAIL sb_drain left=%0d want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
